// File: rtl/fib_seq.sv
// Fibonacci term generator: emits n terms of t0=a, t1=b, tk=t(k-1)+t(k-2)
// on a valid/ready stream, with a sticky carry-out flag.
module fib_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CNT_W-1:0] n,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_idx,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r0_q, r0_d;
    logic [WIDTH-1:0] r1_q, r1_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            r0_q    <= '0;
            r1_q    <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    // Extra MSB captures the carry-out of the modular add.
    assign sum = {1'b0, r0_q} + {1'b0, r1_q};

    always_comb begin
        state_d = state_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ovf_d = 1'b0;
                    if (n != '0) begin
                        r0_d    = a;
                        r1_d    = b;
                        rem_d   = n;
                        idx_d   = '0;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    r0_d  = r1_q;
                    r1_d  = sum[WIDTH-1:0];
                    idx_d = idx_q + CNT_W'(1);
                    rem_d = rem_q - CNT_W'(1);
                    if (sum[WIDTH]) begin
                        ovf_d = 1'b1;
                    end
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out       = r0_q;
    assign out_idx   = idx_q;
    assign out_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fib_seq.sv
// Scoreboard bench for fib_seq: directed runs queue hand-computed terms,
// a negedge monitor pops and compares each transferred term.
module tb_fib_seq;

    localparam int W = 32;
    localparam int C = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [C-1:0] n;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic [C-1:0] out_idx;
    logic         busy;
    logic         done;
    logic         ovf;

    always #5 clk = ~clk;

    fib_seq #(.WIDTH(W), .CNT_W(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .n         (n),
        .out_ready (out_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] v;
        logic [C-1:0] k;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] v, input int k);
        exp_t e;
        e.v = v;
        e.k = C'(k);
        q.push_back(e);
    endtask

    // Monitor: compares every transfer and checks stalls hold steady.
    logic         hold = 1'b0;
    logic [W-1:0] pv;
    logic [C-1:0] pk;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_out", out, pv);
                chk("hold_idx", out_idx, pk);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_term: got %0h idx %0d expected none",
                             out, out_idx);
                end else begin
                    e = q.pop_front();
                    chk("term", out, e.v);
                    chk("term_idx", out_idx, e.k);
                end
            end
            hold = out_valid && !out_ready;
            pv   = out;
            pk   = out_idx;
        end
    end

    // mode 0: ready high; 1: ready 1,0,0 repeating;
    // 2: start with other seeds mid-run; 3: rst raised while idx 3 is shown
    task automatic do_run(input logic [W-1:0] sa, input logic [W-1:0] sb,
                          input logic [C-1:0] sn, input int mode,
                          output int cyc, output logic ovf1,
                          output logic ovf2, output logic anybusy);
        @(posedge clk); #1;
        a = sa;
        b = sb;
        n = sn;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        ovf1 = 1'b0;
        ovf2 = 1'b0;
        anybusy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            cyc++;
            if (busy) anybusy = 1'b1;
            if (cyc == 1) ovf1 = ovf;
            if (cyc == 2) ovf2 = ovf;
            if (done) break;
            if (mode == 3 && cyc == 4) break;
            @(posedge clk); #1;
            case (mode)
                1: out_ready = (cyc % 3 == 0);
                2: begin
                    start = (cyc == 2 || cyc == 3);
                    a = 32'd100;
                    b = 32'd200;
                end
                3: if (cyc == 3) rst = 1'b1;
                default: ;
            endcase
        end
        start = 1'b0;
    endtask

    task automatic push_22(input int cnt);
        logic [W-1:0] t [8];
        t = '{32'd2, 32'd2, 32'd4, 32'd6, 32'd10, 32'd16, 32'd26, 32'd42};
        for (int i = 0; i < cnt; i++) push(t[i], i);
    endtask

    int   cyc;
    logic o1, o2, ab;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        n = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out", out, 0);
        chk("rst_idx", out_idx, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 2,2 series with ready held high
        push_22(8);
        do_run(32'd2, 32'd2, 6'd8, 0, cyc, o1, o2, ab);
        chk("t1_cycles", cyc, 9);
        chk("t1_done", done, 1);
        chk("t1_ovf", ovf, 0);
        chk("t1_drained", q.size(), 0);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);

        // same series under 1,0,0 backpressure
        push_22(8);
        do_run(32'd2, 32'd2, 6'd8, 1, cyc, o1, o2, ab);
        chk("t2_cycles", cyc, 23);
        chk("t2_drained", q.size(), 0);
        @(negedge clk);
        chk("t2_done_pulse", done, 0);

        // carry out of the first sum sets sticky ovf
        push(32'h8000_0000, 0);
        push(32'h8000_0000, 1);
        push(32'h0000_0000, 2);
        do_run(32'h8000_0000, 32'h8000_0000, 6'd3, 0, cyc, o1, o2, ab);
        chk("t3_cycles", cyc, 4);
        chk("t3_ovf_before", o1, 0);
        chk("t3_ovf_after", o2, 1);
        chk("t3_ovf_done", ovf, 1);
        chk("t3_drained", q.size(), 0);

        // n=0: immediate done, no terms, clears ovf
        do_run(32'd5, 32'd7, 6'd0, 0, cyc, o1, o2, ab);
        chk("t4_cycles", cyc, 1);
        chk("t4_busy", ab, 0);
        chk("t4_valid", out_valid, 0);
        chk("t4_ovf_clr", ovf, 0);

        // start mid-run is ignored
        push(32'd1, 0);
        push(32'd1, 1);
        push(32'd2, 2);
        push(32'd3, 3);
        push(32'd5, 4);
        do_run(32'd1, 32'd1, 6'd5, 2, cyc, o1, o2, ab);
        chk("t5_cycles", cyc, 6);
        chk("t5_drained", q.size(), 0);
        repeat (3) @(negedge clk);
        chk("t5_idle_busy", busy, 0);

        // reset while idx 3 is on the output
        push(32'h8000_0000, 0);
        push(32'h8000_0000, 1);
        push(32'h0000_0000, 2);
        do_run(32'h8000_0000, 32'h8000_0000, 6'd8, 3, cyc, o1, o2, ab);
        chk("t6_at_idx3", out_idx, 3);
        chk("t6_ovf_pre", ovf, 1);
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_out", out, 0);
        chk("t6_ovf", ovf, 0);
        chk("t6_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_drained", q.size(), 0);
        o1 = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done) o1 = 1'b1;
        end
        chk("t6_no_done", o1, 0);

        // fresh run after reset
        push_22(8);
        do_run(32'd2, 32'd2, 6'd8, 0, cyc, o1, o2, ab);
        chk("t7_cycles", cyc, 9);
        chk("t7_drained", q.size(), 0);
        chk("t7_ovf", ovf, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
